data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the core's data-memory port: accepts the `wr`/`rd`/`addr`/`wr_data` requests driven by the RISC-V datapath and returns `rd_data`. It holds a 512-byte word-organised store and decodes the access size from Funct3 into byte lanes. Read data is returned one cycle after the request, sign- or zero-extended. The block also keeps sticky misalignment status and access counters for the testbench and for debug.

## Interface
- `DATA_W`, 32, data word width (fixed at 32; other values unsupported)
- `ADDR_W`, 9, byte address width
- `DEPTH`, 128, number of 32-bit words (2^(ADDR_W-2))
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `wr`  in  1  store request, sampled at rising edge
- `rd`  in  1  load request, sampled at rising edge
- `addr`  in  ADDR_W  byte address; word index `addr[8:2]`, lane `addr[1:0]`
- `funct3`  in  3  access size/sign from the load/store instruction
- `wr_data`  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
- `rd_data`  out  DATA_W  extended load result, registered
- `rd_valid`  out  1  one-cycle pulse marking new `rd_data`
- `misaligned`  out  1  sticky: an illegal or misaligned access was rejected
- `err_addr`  out  ADDR_W  address of the first rejected access
- `wr_count`  out  16  accepted stores, wraps
- `rd_count`  out  16  accepted loads, wraps

## Operation
- **Reset.** Reset is synchronous and active-high and dominates every other input.
  - Reset values: `rd_data`=0, `rd_valid`=0, `misaligned`=0, `err_addr`=0, `wr_count`=0, `rd_count`=0.
  - Storage array is not cleared.
  - A request sampled in a reset cycle is discarded and the array is left unchanged.
- **Store** (`wr`=1 at edge):
  - funct3 000 (SB): byte lane `addr[1:0]` ← `wr_data[7:0]`.
  - funct3 001 (SH): half lane `addr[1]` ← `wr_data[15:0]`.
  - funct3 010 (SW): full word ← `wr_data`.
  - Unwritten lanes keep their value.
  - An accepted store increments `wr_count`.
- **Load** (`rd`=1 at edge): reads the word at `addr[8:2]` and selects the lane.
  - funct3 000 (LB): sign-extend the byte.
  - funct3 001 (LH): sign-extend the half.
  - funct3 010 (LW): the whole word.
  - funct3 100 (LBU): zero-extend the byte.
  - funct3 101 (LHU): zero-extend the half.
  - An accepted load increments `rd_count`.
- **Rejection.** An access is rejected when:
  - it is a half access with `addr[0]`=1;
  - it is a word access with `addr[1:0]`≠0;
  - it is a store with funct3 ∉ {000,001,010};
  - it is a load with funct3 ∉ {000,001,010,100,101}.
- **On rejection:**
  - The array is untouched and no counter increments.
  - `misaligned` is set to 1.
  - `err_addr` captures `addr` only if `misaligned` was 0 (first error wins). `misaligned` clears only on reset.
  - A rejected load produces no `rd_valid`, and `rd_data` holds its previous value.
- **Simultaneous `wr` and `rd`** in the same cycle (not produced by the core, but defined):
  - Both use the same `addr` and `funct3`.
  - The load returns the pre-store contents (read-before-write).
  - Both counters increment if the access is legal; if illegal, both are rejected and a single error is recorded.
- **Counter wrap.** Counters wrap from 0xFFFF to 0x0000 with no flag.

## Timing
- Store: the array is updated at the edge that samples `wr`, and is visible to a load sampled at the next edge.
- Load latency is 1 cycle: a request sampled at edge N puts `rd_data`/`rd_valid` valid from after edge N until edge N+1.
- `rd_valid` is high for exactly one cycle per accepted load.
- Back-to-back loads on consecutive edges give `rd_valid` high continuously, with `rd_data` updating every cycle.
- `rd_data` holds its value whenever `rd_valid`=0.
- Reset asserted at edge N+1 following a load at edge N: `rd_valid` and `rd_data` go to 0 at edge N+1.
- No internal wait states; every legal request completes in one edge (no back-pressure to the core).
- `misaligned`, `err_addr`, and the counters update at the same edge as the offending or accepted access.

## Test plan
- **Word round trip.** After reset, SW `addr`=0x010, `wr_data`=0xDEADBEEF, then LW 0x010 → `rd_data`=0xDEADBEEF with `rd_valid` pulsing on the cycle after the load edge; `wr_count`=1, `rd_count`=1.
- **Byte/half merge and extension.** With word 0x010 holding 0xDEADBEEF, SB 0x012 with 0x55 → word becomes 0xDE55BEEF.
  - LB 0x013 → 0xFFFFFFDE.
  - LBU 0x013 → 0x000000DE.
  - LH 0x010 → 0xFFFFBEEF.
  - LHU 0x012 → 0x0000DE55.
- **Misalignment.** With word 0x010 holding 0xDE55BEEF:
  - SW 0x011 → array unchanged, `misaligned`=1, `err_addr`=0x011.
  - Then LH 0x003 → no `rd_valid`, `err_addr` stays 0x011, counters unchanged.
  - Then reset → all status 0.
- **Simultaneous read/write.** With word 0x020 holding 0x11111111, the same edge carries `wr`=`rd`=1, SW 0x020, data 0x22222222 → `rd_data`=0x11111111; a following LW 0x020 → 0x22222222.
- **Reset mid-operation.** LW on edge N, reset on edge N+1 → `rd_valid`=0 and `rd_data`=0 after N+1. A store presented during the reset cycle leaves the array unchanged (checked by a later load).
- **Counter wrap.** 65 536 accepted SW → `wr_count` returns to 0x0000.

Source files
------------

// File: rtl/data_mem_responder.sv
// Responder side of the core's data-memory port: 512-byte word store with
// byte/half/word lanes, registered extended loads, sticky misalignment status and access counters.
module data_mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 128
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              misaligned_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [15:0]       wr_count_o,
  output logic [15:0]       rd_count_o
);

  localparam int IDX_W = ADDR_W - 2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  idx_s;
  logic [1:0]        lane_s;
  logic              wr_ok_s, rd_ok_s, reject_s, wr_acc_s, rd_acc_s;
  logic [3:0]        be_s;
  logic [DATA_W-1:0] wdata_s, rd_word_s, rd_ext_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;

  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_valid_d, rd_valid_q;
  logic              misaligned_d, misaligned_q;
  logic [ADDR_W-1:0] err_addr_d, err_addr_q;
  logic [15:0]       wr_count_d, wr_count_q, rd_count_d, rd_count_q;

  assign idx_s  = addr_i[ADDR_W-1:2];
  assign lane_s = addr_i[1:0];

  // Legality of the request; a bad pairing rejects both halves of a simultaneous access.
  always_comb begin
    wr_ok_s = 1'b0;
    rd_ok_s = 1'b0;
    case (funct3_i)
      3'b000, 3'b100: begin
        wr_ok_s = (funct3_i == 3'b000);
        rd_ok_s = 1'b1;
      end
      3'b001, 3'b101: begin
        wr_ok_s = (funct3_i == 3'b001) && !addr_i[0];
        rd_ok_s = !addr_i[0];
      end
      3'b010: begin
        wr_ok_s = (lane_s == 2'b00);
        rd_ok_s = (lane_s == 2'b00);
      end
      default: begin
        wr_ok_s = 1'b0;
        rd_ok_s = 1'b0;
      end
    endcase
    reject_s = (wr_i && !wr_ok_s) || (rd_i && !rd_ok_s);
    wr_acc_s = wr_i && !reject_s;
    rd_acc_s = rd_i && !reject_s;
  end

  // Store lane enables; data is replicated so each enabled lane already sees its bytes.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = wr_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_s    = 4'b0001 << lane_s;
        wdata_s = {4{wr_data_i[7:0]}};
      end
      2'b01: begin
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{wr_data_i[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = wr_data_i;
      end
    endcase
  end

  // Load lane selection and sign/zero extension from the pre-store word.
  always_comb begin
    rd_word_s = mem_q[idx_s];
    byte_s    = rd_word_s[{lane_s, 3'b000} +: 8];
    half_s    = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    case (funct3_i)
      3'b000:  rd_ext_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  rd_ext_s = {{16{half_s[15]}}, half_s};
      3'b100:  rd_ext_s = {24'd0, byte_s};
      3'b101:  rd_ext_s = {16'd0, half_s};
      default: rd_ext_s = rd_word_s;
    endcase
  end

  // Next-state for the load result, sticky error capture and counters.
  always_comb begin
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_acc_s;
    misaligned_d = misaligned_q | reject_s;
    err_addr_d   = err_addr_q;
    wr_count_d   = wr_count_q;
    rd_count_d   = rd_count_q;
    if (rd_acc_s) begin
      rd_data_d  = rd_ext_s;
      rd_count_d = rd_count_q + 16'd1;
    end else begin
      rd_data_d  = rd_data_q;
    end
    if (wr_acc_s) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
    if (reject_s && !misaligned_q) begin
      err_addr_d = addr_i;
    end else begin
      err_addr_d = err_addr_q;
    end
  end

  // Status and result registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      err_addr_q   <= '0;
      wr_count_q   <= 16'd0;
      rd_count_q   <= 16'd0;
    end else begin
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      misaligned_q <= misaligned_d;
      err_addr_q   <= err_addr_d;
      wr_count_q   <= wr_count_d;
      rd_count_q   <= rd_count_d;
    end
  end

  // Storage array: never cleared, and a store seen during reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_acc_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign misaligned_o = misaligned_q;
  assign err_addr_o   = err_addr_q;
  assign wr_count_o   = wr_count_q;
  assign rd_count_o   = rd_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_data_mem_responder;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0, wr_i = 1'b0, rd_i = 1'b0;
  logic [8:0]  addr_i = 9'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] wr_data_i = 32'd0;
  logic [31:0] rd_data_o;
  logic        rd_valid_o, misaligned_o;
  logic [8:0]  err_addr_o;
  logic [15:0] wr_count_o, rd_count_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [512];
  logic [31:0] m_rd = 32'd0;
  logic        m_valid = 1'b0, m_mis = 1'b0;
  logic [8:0]  m_err = 9'd0;
  logic [15:0] m_wc = 16'd0, m_rc = 16'd0;

  data_mem_responder dut (
    .clk_i(clk_i), .reset_i(reset_i), .wr_i(wr_i), .rd_i(rd_i), .addr_i(addr_i),
    .funct3_i(funct3_i), .wr_data_i(wr_data_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .misaligned_o(misaligned_o), .err_addr_o(err_addr_o),
    .wr_count_o(wr_count_o), .rd_count_o(rd_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_step(input logic w, input logic r, input logic rst,
                            input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
    int n;
    bit st_ok, ld_ok, rej;
    logic [31:0] v;
    n = 1 << f[1:0];
    st_ok = (f == 3'd0 || f == 3'd1 || f == 3'd2) && (int'(a) % n == 0);
    ld_ok = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5) && (int'(a) % n == 0);
    rej = (w && !st_ok) || (r && !ld_ok);
    if (rst) begin
      m_rd = 32'd0; m_valid = 1'b0; m_mis = 1'b0; m_err = 9'd0; m_wc = 16'd0; m_rc = 16'd0;
    end else if (rej) begin
      if (!m_mis) m_err = a;
      m_mis = 1'b1;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (r) begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_m[int'(a) + i]) << (8 * i));
        if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        m_rd = v;
        m_valid = 1'b1;
        m_rc = m_rc + 16'd1;
      end
      if (w) begin
        for (int i = 0; i < n; i++) mem_m[int'(a) + i] = d[8*i +: 8];
        m_wc = m_wc + 16'd1;
      end
    end
  endtask

  // One clock: present inputs on the falling edge, let the rising edge sample, settle 1 ns.
  task automatic cycle(input logic w, input logic r, input logic rst,
                       input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
    @(negedge clk_i);
    wr_i = w; rd_i = r; reset_i = rst; addr_i = a; funct3_i = f; wr_data_i = d;
    model_step(w, r, rst, a, f, d);
    @(posedge clk_i);
    #1;
    wr_i = 1'b0; rd_i = 1'b0; reset_i = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b1, 9'd0, 3'd0, 32'd0);
    checks++; if (rd_data_o !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data_o); end
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid_o); end
    checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL reset_misaligned got %b want 0", misaligned_o); end
    checks++; if (err_addr_o !== 9'd0) begin errors++; $display("FAIL reset_err_addr got %h want 0", err_addr_o); end
    checks++; if (wr_count_o !== 16'd0 || rd_count_o !== 16'd0) begin
      errors++; $display("FAIL reset_counts got wr=%h rd=%h want 0/0", wr_count_o, rd_count_o); end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 128; i++) cycle(1'b1, 1'b0, 1'b0, 9'(i * 4), 3'd2, $urandom);
    checks++; if (wr_count_o !== 16'd128) begin errors++; $display("FAIL init_wr_count got %h want 0080", wr_count_o); end
    cycle(1'b0, 1'b0, 1'b1, 9'd0, 3'd0, 32'd0);
  endtask

  task automatic test_word_round_trip();
    cycle(1'b1, 1'b0, 1'b0, 9'h010, 3'd2, 32'hDEAD_BEEF);
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL wrt_store_valid got %b want 0", rd_valid_o); end
    cycle(1'b0, 1'b1, 1'b0, 9'h010, 3'd2, 32'd0);
    checks++; if (rd_data_o !== 32'hDEAD_BEEF || rd_valid_o !== 1'b1) begin
      errors++; $display("FAIL wrt_load got %h/%b want deadbeef/1", rd_data_o, rd_valid_o); end
    checks++; if (wr_count_o !== 16'd1 || rd_count_o !== 16'd1) begin
      errors++; $display("FAIL wrt_counts got %h/%h want 1/1", wr_count_o, rd_count_o); end
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 32'd0);
    checks++; if (rd_valid_o !== 1'b0 || rd_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wrt_hold got %h/%b want deadbeef/0", rd_data_o, rd_valid_o); end
  endtask

  task automatic test_byte_half();
    logic [8:0]  a_t [5];
    logic [2:0]  f_t [5];
    logic [31:0] e_t [5];
    a_t = '{9'h013, 9'h013, 9'h010, 9'h012, 9'h010};
    f_t = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    e_t = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_BEEF, 32'h0000_DE55, 32'hDE55_BEEF};
    cycle(1'b1, 1'b0, 1'b0, 9'h012, 3'd0, 32'hAABB_CC55);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, a_t[i], f_t[i], 32'd0);
      checks++; if (rd_data_o !== e_t[i] || rd_valid_o !== 1'b1) begin
        errors++; $display("FAIL bytehalf_%0d got %h/%b want %h/1", i, rd_data_o, rd_valid_o, e_t[i]); end
    end
  endtask

  task automatic test_misalign();
    logic [15:0] wc, rc;
    wc = wr_count_o; rc = rd_count_o;
    cycle(1'b1, 1'b0, 1'b0, 9'h011, 3'd2, 32'h1234_5678);
    checks++; if (misaligned_o !== 1'b1 || err_addr_o !== 9'h011 || wr_count_o !== wc) begin
      errors++; $display("FAIL mis_sw got mis=%b err=%h wc=%h want 1/011/%h", misaligned_o, err_addr_o, wr_count_o, wc); end
    cycle(1'b0, 1'b1, 1'b0, 9'h003, 3'd1, 32'd0);
    checks++; if (rd_valid_o !== 1'b0 || err_addr_o !== 9'h011 || rd_count_o !== rc || rd_data_o !== 32'hDE55_BEEF) begin
      errors++; $display("FAIL mis_lh got v=%b err=%h rc=%h d=%h want 0/011/%h/de55beef", rd_valid_o, err_addr_o, rd_count_o, rd_data_o, rc); end
    cycle(1'b0, 1'b1, 1'b0, 9'h010, 3'd2, 32'd0);
    checks++; if (rd_data_o !== 32'hDE55_BEEF) begin errors++; $display("FAIL mis_array got %h want de55beef", rd_data_o); end
    cycle(1'b0, 1'b0, 1'b1, 9'd0, 3'd0, 32'd0);
    checks++; if (misaligned_o !== 1'b0 || err_addr_o !== 9'd0 || wr_count_o !== 16'd0 || rd_count_o !== 16'd0) begin
      errors++; $display("FAIL mis_reset got mis=%b err=%h wc=%h rc=%h want zeros", misaligned_o, err_addr_o, wr_count_o, rd_count_o); end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 1'b0, 1'b0, 9'h020, 3'd2, 32'h1111_1111);
    cycle(1'b1, 1'b1, 1'b0, 9'h020, 3'd2, 32'h2222_2222);
    checks++; if (rd_data_o !== 32'h1111_1111 || rd_valid_o !== 1'b1) begin
      errors++; $display("FAIL simul_rbw got %h/%b want 11111111/1", rd_data_o, rd_valid_o); end
    checks++; if (wr_count_o !== 16'd2 || rd_count_o !== 16'd1) begin
      errors++; $display("FAIL simul_counts got %h/%h want 2/1", wr_count_o, rd_count_o); end
    cycle(1'b0, 1'b1, 1'b0, 9'h020, 3'd2, 32'd0);
    checks++; if (rd_data_o !== 32'h2222_2222) begin errors++; $display("FAIL simul_after got %h want 22222222", rd_data_o); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 1'b0, 9'h020, 3'd2, 32'd0);
    checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_load got %b want 1", rd_valid_o); end
    cycle(1'b1, 1'b0, 1'b1, 9'h020, 3'd2, 32'h3333_3333);
    checks++; if (rd_valid_o !== 1'b0 || rd_data_o !== 32'd0) begin
      errors++; $display("FAIL rstmid_clear got %h/%b want 0/0", rd_data_o, rd_valid_o); end
    cycle(1'b0, 1'b1, 1'b0, 9'h020, 3'd2, 32'd0);
    checks++; if (rd_data_o !== 32'h2222_2222 || wr_count_o !== 16'd0) begin
      errors++; $display("FAIL rstmid_store got %h wc=%h want 22222222/0", rd_data_o, wr_count_o); end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [8:0] a;
    for (int c = 0; c < 600; c++) begin
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'(($urandom_range(0, 4) < 3) ? $urandom_range(0, 2) : $urandom_range(4, 5));
      a = 9'($urandom);
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 60) == 0), a, f, $urandom);
      checks++; if (rd_data_o !== m_rd || rd_valid_o !== m_valid) begin
        errors++; $display("FAIL rand_rd_%0d got %h/%b want %h/%b", c, rd_data_o, rd_valid_o, m_rd, m_valid); end
      checks++; if (misaligned_o !== m_mis || err_addr_o !== m_err) begin
        errors++; $display("FAIL rand_err_%0d got %b/%h want %b/%h", c, misaligned_o, err_addr_o, m_mis, m_err); end
      checks++; if (wr_count_o !== m_wc || rd_count_o !== m_rc) begin
        errors++; $display("FAIL rand_cnt_%0d got %h/%h want %h/%h", c, wr_count_o, rd_count_o, m_wc, m_rc); end
    end
  endtask

  task automatic test_counter_wrap();
    cycle(1'b0, 1'b0, 1'b1, 9'd0, 3'd0, 32'd0);
    for (int i = 0; i < 65535; i++) cycle(1'b1, 1'b0, 1'b0, 9'h040, 3'd2, 32'(i));
    checks++; if (wr_count_o !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h want ffff", wr_count_o); end
    cycle(1'b1, 1'b0, 1'b0, 9'h040, 3'd2, 32'h0BAD_F00D);
    checks++; if (wr_count_o !== 16'h0000 || misaligned_o !== 1'b0) begin
      errors++; $display("FAIL wrap_zero got %h/%b want 0000/0", wr_count_o, misaligned_o); end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_word_round_trip();
    test_byte_half();
    test_misalign();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
